// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble sequencing for the 5-stage core: load-use, taken-branch squash,
// and data-memory waits with timeout, plus saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXRegRd,
    input  logic [4:0]       IFIDR1,
    input  logic [4:0]       IFIDR2,
    input  logic             IFIDUsesR2,
    input  logic             BranchTaken,
    input  logic             EXMEMMemRead,
    input  logic             EXMEMMemWrite,
    input  logic             DMemReady,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             MEMWBBubble,
    output logic             MemError,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic memstall;
    logic loaduse;
    logic freeze;
    logic advance;

    assign memstall = (EXMEMMemRead | EXMEMMemWrite) & ~DMemReady;
    assign loaduse  = IDEXMemRead & (IDEXRegRd != 5'd0) &
                      ((IDEXRegRd == IFIDR1) | (IFIDUsesR2 & (IDEXRegRd == IFIDR2)));

    // Next state and hazard decision; advance marks a cycle where the pipeline may move
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (memstall) begin
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!DMemReady) begin
                    freeze = 1'b1;
                    if (wait_cnt_q == TIMEOUT_C) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    advance    = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Control outputs; a branch outranks load-use since the ID instruction is squashed anyway
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        EXMEMWrite  = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        MEMWBBubble = 1'b0;
        if (freeze) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMWrite  = 1'b0;
            MEMWBBubble = 1'b1;
        end else if (advance && BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (advance && loaduse) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    // Saturating statistics
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PCWrite && (state_q != ST_ERROR) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IFIDFlush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemError    = (state_q == ST_ERROR);
    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule
